enc_frontend: RTL and testbench

- Upstream input stage for the RGB mixer: one instance per rotary encoder.
- Turns raw, asynchronous, bouncy quadrature pad inputs into a clean, registered colour-level value plus single-cycle step strobes.
- Its value feeds the PWM duty-cycle input of the mixer's PWM channel; three instances cover R, G and B.
- Also provides a synchronous load so firmware (via LA/wishbone) can preset a level.

---
 rtl/enc_pkg.sv | 32 +++
 rtl/enc_debounce.sv | 46 ++++
 rtl/enc_frontend.sv | 142 ++++++++++++++
 tb/tb_enc_frontend.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the rotary-encoder front end.
// Holds the default parameter values and the step-direction type used by
// the quadrature decode and by anything that needs to reason about steps.
package enc_pkg;

  localparam int ENC_WIDTH    = 8;
  localparam int ENC_DEBOUNCE = 16;
  localparam int ENC_STEP     = 1;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  // x1 decode: a step is taken only on a clean A rising edge; B at that
  // moment gives the direction. An illegal transition suppresses the step.
  function automatic dir_e decode_dir(input logic a_rise, input logic b_level,
                                      input logic illegal);
    dir_e d;
    d = DIR_NONE;
    if (illegal) begin
      d = DIR_NONE;
    end else if (a_rise) begin
      d = b_level ? DIR_DOWN : DIR_UP;
    end else begin
      d = DIR_NONE;
    end
    return d;
  endfunction

endpackage

// File: rtl/enc_debounce.sv
// Single-channel debouncer for an already-synchronised encoder signal.
// The clean output follows the input only after it has disagreed with the
// clean level for DEBOUNCE_CYCLES consecutive cycles; one agreeing cycle
// restarts the count.
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   in_sync   synchronised (but bouncy) input
//   out_clean debounced, registered level
module enc_debounce
  import enc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = ENC_DEBOUNCE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_sync,
  output logic out_clean
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_r;
  logic          clean_r;

  // Stability counter and clean level; the toggle and counter clear share one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= '0;
      clean_r <= 1'b0;
    end else if (in_sync != clean_r) begin
      if (cnt_r == LAST) begin
        clean_r <= ~clean_r;
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= '0;
    end
  end

  assign out_clean = clean_r;

endmodule

// File: rtl/enc_frontend.sv
// Rotary-encoder input stage: synchronises and debounces the raw quadrature
// pads, decodes x1 steps on clean A rising edges and maintains a registered
// level that feeds a PWM duty cycle. Firmware can preset the level.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   enc_a, enc_b      raw asynchronous encoder channels
//   load, load_value  synchronous preset (wins over a coincident step)
//   value             current level, registered
//   inc_pulse         one-cycle strobe per up step (also when saturated)
//   dec_pulse         one-cycle strobe per down step (also when saturated)
//   err               one-cycle strobe when both clean channels flip together
module enc_frontend
  import enc_pkg::*;
#(
  parameter int WIDTH           = ENC_WIDTH,
  parameter int DEBOUNCE_CYCLES = ENC_DEBOUNCE,
  parameter int STEP            = ENC_STEP,
  parameter int WRAP            = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             inc_pulse,
  output logic             dec_pulse,
  output logic             err
);

  localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);

  logic a_meta_r, a_sync_r, b_meta_r, b_sync_r;
  logic clean_a_s, clean_b_s, clean_a_d_r, clean_b_d_r;
  logic a_rise_s, illegal_s;
  dir_e dir_s;
  logic [WIDTH:0]   sum_s, diff_s;
  logic [WIDTH-1:0] next_value_s, value_r;
  logic             next_inc_s, next_dec_s, inc_r, dec_r, err_r;

  // Plain two-flop synchronisers, no logic between the stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_meta_r <= 1'b0;
      a_sync_r <= 1'b0;
      b_meta_r <= 1'b0;
      b_sync_r <= 1'b0;
    end else begin
      a_meta_r <= enc_a;
      a_sync_r <= a_meta_r;
      b_meta_r <= enc_b;
      b_sync_r <= b_meta_r;
    end
  end

  enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_sync   (a_sync_r),
    .out_clean (clean_a_s)
  );

  enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_sync   (b_sync_r),
    .out_clean (clean_b_s)
  );

  // Delayed clean levels for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clean_a_d_r <= 1'b0;
      clean_b_d_r <= 1'b0;
    end else begin
      clean_a_d_r <= clean_a_s;
      clean_b_d_r <= clean_b_s;
    end
  end

  assign a_rise_s  = clean_a_s & ~clean_a_d_r;
  assign illegal_s = (clean_a_s ^ clean_a_d_r) & (clean_b_s ^ clean_b_d_r);
  assign dir_s     = decode_dir(a_rise_s, clean_b_s, illegal_s);

  // One extra bit exposes carry (up overflow) and borrow (down underflow).
  assign sum_s  = {1'b0, value_r} + STEP_W;
  assign diff_s = {1'b0, value_r} - STEP_W;

  // Next level and strobes; load discards a coincident step.
  always_comb begin
    next_value_s = value_r;
    next_inc_s   = 1'b0;
    next_dec_s   = 1'b0;
    if (load) begin
      next_value_s = load_value;
    end else begin
      case (dir_s)
        DIR_UP: begin
          next_inc_s = 1'b1;
          if ((WRAP == 0) && sum_s[WIDTH]) begin
            next_value_s = {WIDTH{1'b1}};
          end else begin
            next_value_s = sum_s[WIDTH-1:0];
          end
        end
        DIR_DOWN: begin
          next_dec_s = 1'b1;
          if ((WRAP == 0) && diff_s[WIDTH]) begin
            next_value_s = '0;
          end else begin
            next_value_s = diff_s[WIDTH-1:0];
          end
        end
        default: begin
          next_value_s = value_r;
        end
      endcase
    end
  end

  // Registered level and strobes; err is reported even when load wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_r <= '0;
      inc_r   <= 1'b0;
      dec_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      value_r <= next_value_s;
      inc_r   <= next_inc_s;
      dec_r   <= next_dec_s;
      err_r   <= illegal_s;
    end
  end

  assign value     = value_r;
  assign inc_pulse = inc_r;
  assign dec_pulse = dec_r;
  assign err       = err_r;

endmodule

// File: tb/tb_enc_frontend.sv
// Bench for enc_frontend: two instances (saturating and wrapping) share the
// same stimulus. A reference model pushes expected strobe events into a
// queue; a separate monitor pops and compares whenever a strobe appears.
module tb_enc_frontend;
  import enc_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         enc_a = 1'b0, enc_b = 1'b0, load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] value0, value1;
  logic         inc0, dec0, err0, inc1, dec1, err1;

  enc_frontend #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .STEP(1), .WRAP(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .load(load),
    .load_value(load_value), .value(value0), .inc_pulse(inc0),
    .dec_pulse(dec0), .err(err0));

  enc_frontend #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .STEP(1), .WRAP(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .load(load),
    .load_value(load_value), .value(value1), .inc_pulse(inc1),
    .dec_pulse(dec1), .err(err1));

  always #5 clk = ~clk;

  typedef struct {
    logic         err;
    dir_e         dir;
    logic [W-1:0] v0;
    logic [W-1:0] v1;
    int           cyc;
  } ev_t;

  ev_t  exp_q[$];
  int   vectors = 0, miscompares = 0;
  int   edge_n = 0;
  int   inc_seen = 0, err_seen = 0, last_inc_edge = 0;

  // reference model state
  int   mv0, mv1;
  logic raw1_a, raw2_a, raw1_b, raw2_b;
  logic mca, mcb;
  logic seen_a[$], seen_b[$];
  dir_e pdir;
  logic perr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    mv0 = 0; mv1 = 0;
    raw1_a = 1'b0; raw2_a = 1'b0; raw1_b = 1'b0; raw2_b = 1'b0;
    mca = 1'b0; mcb = 1'b0;
    seen_a.delete(); seen_b.delete();
    pdir = DIR_NONE; perr = 1'b0;
    exp_q.delete();
  endtask

  // True when the last D synchronised samples all disagree with the clean level.
  function automatic logic settled(input logic q[$], input logic c);
    if (q.size() < D) return 1'b0;
    for (int i = 0; i < D; i++) begin
      if (q[q.size() - 1 - i] == c) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    ev_t  e;
    logic oa, ob, ill;
    // outcome of the event detected on the previous cycle
    if (load) begin
      mv0 = int'(load_value); mv1 = int'(load_value);
    end else if (!perr && pdir == DIR_UP) begin
      mv0 = (mv0 + 1 > 255) ? 255 : mv0 + 1;
      mv1 = (mv1 + 1) % 256;
    end else if (!perr && pdir == DIR_DOWN) begin
      mv0 = (mv0 == 0) ? 0 : mv0 - 1;
      mv1 = (mv1 + 255) % 256;
    end
    if (perr || (!load && pdir != DIR_NONE)) begin
      e.err = perr;
      e.dir = load ? DIR_NONE : pdir;
      e.v0  = mv0[W-1:0];
      e.v1  = mv1[W-1:0];
      e.cyc = edge_n;
      exp_q.push_back(e);
    end
    // the debouncer sees the raw level from two edges ago
    seen_a.push_back(raw2_a); if (seen_a.size() > D) void'(seen_a.pop_front());
    seen_b.push_back(raw2_b); if (seen_b.size() > D) void'(seen_b.pop_front());
    raw2_a = raw1_a; raw1_a = enc_a;
    raw2_b = raw1_b; raw1_b = enc_b;
    oa = mca; ob = mcb;
    if (settled(seen_a, mca)) mca = ~mca;
    if (settled(seen_b, mcb)) mcb = ~mcb;
    ill  = (mca != oa) && (mcb != ob);
    perr = ill;
    pdir = ill ? DIR_NONE : ((mca && !oa) ? (mcb ? DIR_DOWN : DIR_UP) : DIR_NONE);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      edge_n++;
      if (reset_n) model_edge();
      @(negedge clk);
    end
  endtask

  task automatic settle_check(input string tag);
    #1;
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_value_sat"}, value0, mv0);
    check({tag, "_value_wrap"}, value1, mv1);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_value = v;
    tick(1);
    load = 1'b0;
  endtask

  task automatic detent(input logic b);
    enc_b = b;     tick(D + 4);
    enc_a = 1'b1;  tick(10);
    enc_a = 1'b0;  tick(10);
  endtask

  // Monitor: every strobe must match the oldest expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset_n && (inc0 | dec0 | err0 | inc1 | dec1 | err1)) begin
        if (inc0) begin inc_seen++; last_inc_edge = edge_n; end
        if (err0) err_seen++;
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_strobe: got inc=%b dec=%b err=%b at edge %0d, expected none",
                   inc0, dec0, err0, edge_n);
        end else begin
          e = exp_q.pop_front();
          check("strobe_edge", edge_n, e.cyc);
          check("inc_sat",  inc0, e.dir == DIR_UP);
          check("dec_sat",  dec0, e.dir == DIR_DOWN);
          check("err_sat",  err0, e.err);
          check("inc_wrap", inc1, e.dir == DIR_UP);
          check("dec_wrap", dec1, e.dir == DIR_DOWN);
          check("err_wrap", err1, e.err);
          check("strobe_value_sat",  value0, e.v0);
          check("strobe_value_wrap", value1, e.v1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, inc_before, err_before, found;
    logic [W-1:0] v_before;
    model_reset();
    #1 reset_n = 1'b0;
    #20;
    check("reset_value", value0, 0);
    check("reset_strobes", {inc0, dec0, err0}, 0);
    @(negedge clk) reset_n = 1'b1;
    tick(3);

    // 1: clean up detent then down detent, with latency check
    enc_b = 1'b0; tick(D + 4);
    t0 = edge_n;
    enc_a = 1'b1; tick(10);
    check("t1_latency", last_inc_edge - t0, D + 3);
    check("t1_up_value", value0, 1);
    enc_a = 1'b0; tick(10);
    detent(1'b1);
    settle_check("t1");
    check("t1_down_value", value0, 0);

    // 2: bounce rejection
    inc_before = inc_seen; err_before = err_seen;
    enc_b = 1'b0; tick(D + 4);
    enc_a = 1'b1; tick(2); enc_a = 1'b0; tick(2);
    enc_a = 1'b1; tick(2); enc_a = 1'b0; tick(2);
    enc_a = 1'b1; tick(12);
    enc_a = 1'b0; tick(10);
    settle_check("t2");
    check("t2_value", value0, 1);
    check("t2_inc_count", inc_seen - inc_before, 1);
    check("t2_no_err", err_seen - err_before, 0);

    // 3: saturation versus wrap
    do_load(8'd255); detent(1'b0);
    settle_check("t3_up");
    check("t3_up_sat", value0, 255);
    check("t3_up_wrap", value1, 0);
    do_load(8'd0); detent(1'b1);
    settle_check("t3_down");
    check("t3_down_sat", value0, 0);
    check("t3_down_wrap", value1, 255);

    // 4: load coincident with a detected up step
    inc_before = inc_seen;
    enc_b = 1'b0; tick(D + 4);
    enc_a = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick(1);
      if (pdir == DIR_UP) found = 1;
    end
    check("t4_step_detected", found, 1);
    do_load(8'h80);
    tick(8);
    settle_check("t4");
    check("t4_value", value0, 8'h80);
    check("t4_no_inc", inc_seen - inc_before, 0);
    enc_a = 1'b0; tick(10);

    // 5: both channels flip together
    inc_before = inc_seen; err_before = err_seen;
    #1 v_before = value0;
    enc_a = 1'b1; enc_b = 1'b1; tick(12);
    settle_check("t5");
    check("t5_err_count", err_seen - err_before, 1);
    check("t5_value", value0, v_before);
    check("t5_no_inc", inc_seen - inc_before, 0);
    enc_a = 1'b0; enc_b = 1'b0; tick(12);
    settle_check("t5_back");

    // 6: asynchronous reset inside a debounce window
    enc_a = 1'b1; tick(4);
    #2 reset_n = 1'b0;
    #1;
    check("t6_value_sat", value0, 0);
    check("t6_value_wrap", value1, 0);
    check("t6_strobes", {inc0, dec0, err0, inc1, dec1, err1}, 0);
    model_reset();
    enc_a = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(20);
    settle_check("t6");
    check("t6_after_release", value0, 0);

    // random phase: bouncy inputs, illegal flips and loads
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_load(W'($urandom_range(0, 255)));
      end else begin
        enc_a = 1'($urandom_range(0, 1));
        enc_b = 1'($urandom_range(0, 1));
        tick($urandom_range(1, 8));
      end
    end
    tick(2 * D + 10);
    settle_check("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
